// File: rtl/pll_sup_pkg.sv
// Shared definitions for the video PLL lock supervisor: FSM state encoding and
// the counter sizing helper.
package pll_sup_pkg;

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      RELEASE   = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } sup_state_e;

   // A counter sized this way can hold the value v itself, so a count can
   // reach its limit without wrapping.
   function automatic int cnt_w(input int v);
      return $clog2(v) + 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, synchronous active-low
// reset clearing both stages.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Video PLL supervisor: PLL reset, lock filtering with timeout/retry, staggered
// downstream reset release, restart on lock loss or relock request, sticky fault.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// PLL_RST   | PLL held in reset for RST_CYCLES, domains in reset
// WAIT_LOCK | PLL running, filtering lock, timeout counting
// RELEASE   | lock accepted, domain resets released one by one
// RUN       | all domains out of reset, locked_o high
// FAULT     | MAX_RETRIES attempts failed, wait for relock request
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int N_DOMAINS    = 3,
   parameter int RST_CYCLES   = 16,
   parameter int LOCK_FILTER  = 1024,
   parameter int LOCK_TIMEOUT = 500000,
   parameter int STAGGER      = 8,
   parameter int MAX_RETRIES  = 4
) (
   input  logic                 refclk,
   input  logic                 rst_n,
   input  logic                 pll_locked_i,
   input  logic                 relock_req_i,
   output logic                 pll_rst_o,
   output logic [N_DOMAINS-1:0] domain_rst_n_o,
   output logic                 locked_o,
   output logic                 fault_o,
   output logic [3:0]           retry_cnt_o,
   output logic [7:0]           loss_cnt_o
);

   // The phase counter serves both PLL_RST and RELEASE; RELEASE needs one
   // count beyond the last release to step into RUN.
   localparam int REL_END = N_DOMAINS * STAGGER;
   localparam int PH_MAX  = (RST_CYCLES > REL_END) ? RST_CYCLES : REL_END + 1;
   localparam int PH_W    = cnt_w(PH_MAX);
   localparam int FILT_W  = cnt_w(LOCK_FILTER);
   localparam int TMO_W   = cnt_w(LOCK_TIMEOUT);

   localparam logic [PH_W-1:0]   RST_LAST   = PH_W'(RST_CYCLES - 1);
   localparam logic [PH_W-1:0]   REL_LAST   = PH_W'(REL_END);
   localparam logic [FILT_W-1:0] FILT_LIMIT = FILT_W'(LOCK_FILTER);
   localparam logic [TMO_W-1:0]  TMO_LIMIT  = TMO_W'(LOCK_TIMEOUT);
   localparam logic [3:0]        RETRY_MAX  = 4'(MAX_RETRIES);

   sup_state_e          state, state_nx;
   logic [PH_W-1:0]     phase, phase_nx;
   logic [FILT_W-1:0]   filt, filt_nx;
   logic [TMO_W-1:0]    tmo, tmo_nx;
   logic [3:0]          retry_nx;
   logic [7:0]          loss_nx;
   logic [N_DOMAINS-1:0] dom_nx;
   logic                lk_s;

   sync_2ff u_lock_sync (
      .clk   (refclk),
      .rst_n (rst_n),
      .d     (pll_locked_i),
      .q     (lk_s)
   );

   always_comb begin
      state_nx = state;
      phase_nx = phase;
      filt_nx  = '0;
      tmo_nx   = '0;
      retry_nx = retry_cnt_o;
      loss_nx  = loss_cnt_o;
      dom_nx   = '0;

      unique case (state)
         PLL_RST: begin
            if (relock_req_i) begin
               phase_nx = '0;
            end else if (phase == RST_LAST) begin
               state_nx = WAIT_LOCK;
               phase_nx = '0;
            end else begin
               phase_nx = phase + PH_W'(1);
            end
         end

         WAIT_LOCK: begin
            filt_nx = lk_s ? filt + FILT_W'(1) : '0;
            tmo_nx  = tmo + TMO_W'(1);
            if (relock_req_i) begin
               state_nx = PLL_RST;
               phase_nx = '0;
            end else if (filt_nx == FILT_LIMIT) begin
               state_nx = RELEASE;
               phase_nx = '0;
            end else if (tmo_nx == TMO_LIMIT) begin
               retry_nx = retry_cnt_o + 4'd1;
               state_nx = (retry_nx == RETRY_MAX) ? FAULT : PLL_RST;
               phase_nx = '0;
            end
         end

         RELEASE, RUN: begin
            // A simultaneous loss and relock request restarts once and still
            // counts as a loss.
            if (!lk_s || relock_req_i) begin
               state_nx = PLL_RST;
               phase_nx = '0;
               if (!lk_s && loss_cnt_o != 8'hff) loss_nx = loss_cnt_o + 8'd1;
            end else if (state == RELEASE) begin
               if (phase == REL_LAST) begin
                  state_nx = RUN;
                  phase_nx = '0;
                  retry_nx = '0;
               end else begin
                  phase_nx = phase + PH_W'(1);
               end
            end
         end

         FAULT: begin
            if (relock_req_i) begin
               state_nx = PLL_RST;
               phase_nx = '0;
               retry_nx = '0;
            end
         end

         default: begin
            state_nx = PLL_RST;
            phase_nx = '0;
         end
      endcase

      for (int i = 0; i < N_DOMAINS; i++) begin
         dom_nx[i] = (state_nx == RUN) ||
                     ((state_nx == RELEASE) && (int'(phase_nx) >= (i + 1) * STAGGER));
      end
   end

   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         state          <= PLL_RST;
         phase          <= '0;
         filt           <= '0;
         tmo            <= '0;
         retry_cnt_o    <= '0;
         loss_cnt_o     <= '0;
         pll_rst_o      <= 1'b1;
         domain_rst_n_o <= '0;
         locked_o       <= 1'b0;
         fault_o        <= 1'b0;
      end else begin
         state          <= state_nx;
         phase          <= phase_nx;
         filt           <= filt_nx;
         tmo            <= tmo_nx;
         retry_cnt_o    <= retry_nx;
         loss_cnt_o     <= loss_nx;
         pll_rst_o      <= (state_nx == PLL_RST) || (state_nx == FAULT);
         domain_rst_n_o <= dom_nx;
         locked_o       <= (state_nx == RUN);
         fault_o        <= (state_nx == FAULT);
      end
   end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios plus random lock/relock
// traffic, all outputs compared every cycle against a mode/age reference model.
module tb_pll_lock_supervisor;

   localparam int N_DOMAINS    = 3;
   localparam int RST_CYCLES   = 4;
   localparam int LOCK_FILTER  = 8;
   localparam int LOCK_TIMEOUT = 64;
   localparam int STAGGER      = 2;
   localparam int MAX_RETRIES  = 3;

   logic                 refclk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 pll_locked_i = 1'b0;
   logic                 relock_req_i = 1'b0;
   logic                 pll_rst_o;
   logic [N_DOMAINS-1:0] domain_rst_n_o;
   logic                 locked_o;
   logic                 fault_o;
   logic [3:0]           retry_cnt_o;
   logic [7:0]           loss_cnt_o;

   int total = 0;
   int bad   = 0;

   pll_lock_supervisor #(
      .N_DOMAINS    (N_DOMAINS),
      .RST_CYCLES   (RST_CYCLES),
      .LOCK_FILTER  (LOCK_FILTER),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .STAGGER      (STAGGER),
      .MAX_RETRIES  (MAX_RETRIES)
   ) dut (
      .refclk         (refclk),
      .rst_n          (rst_n),
      .pll_locked_i   (pll_locked_i),
      .relock_req_i   (relock_req_i),
      .pll_rst_o      (pll_rst_o),
      .domain_rst_n_o (domain_rst_n_o),
      .locked_o       (locked_o),
      .fault_o        (fault_o),
      .retry_cnt_o    (retry_cnt_o),
      .loss_cnt_o     (loss_cnt_o)
   );

   always #5 refclk = ~refclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: the supervisor is in one mode for some number of cycles
   // (age); outputs follow from mode and age alone.
   localparam int M_RST = 0, M_WAIT = 1, M_REL = 2, M_RUN = 3, M_FLT = 4;
   int m_mode = M_RST, m_age = 0, m_run = 0, m_retry = 0, m_loss = 0;
   bit h1 = 1'b0, h2 = 1'b0;

   task automatic enter(input int mode);
      m_mode = mode;
      m_age  = 0;
      m_run  = 0;
   endtask

   task automatic model_edge();
      bit lk;
      lk = h2;
      if (!rst_n) begin
         enter(M_RST);
         m_retry = 0;
         m_loss  = 0;
         h1 = 1'b0;
         h2 = 1'b0;
         return;
      end
      h2 = h1;
      h1 = pll_locked_i;
      m_age++;
      case (m_mode)
         M_RST: begin
            if (relock_req_i) enter(M_RST);
            else if (m_age == RST_CYCLES) enter(M_WAIT);
         end
         M_WAIT: begin
            m_run = lk ? m_run + 1 : 0;
            if (relock_req_i) enter(M_RST);
            else if (m_run == LOCK_FILTER) enter(M_REL);
            else if (m_age == LOCK_TIMEOUT) begin
               m_retry++;
               enter((m_retry == MAX_RETRIES) ? M_FLT : M_RST);
            end
         end
         M_REL, M_RUN: begin
            if (!lk || relock_req_i) begin
               if (!lk && m_loss < 255) m_loss++;
               enter(M_RST);
            end else if (m_mode == M_REL && m_age == N_DOMAINS * STAGGER + 1) begin
               m_retry = 0;
               enter(M_RUN);
            end
         end
         default: begin
            if (relock_req_i) begin
               m_retry = 0;
               enter(M_RST);
            end
         end
      endcase
   endtask

   function automatic logic [31:0] exp_dom();
      logic [31:0] d;
      d = '0;
      for (int i = 0; i < N_DOMAINS; i++) begin
         if (m_mode == M_RUN) d[i] = 1'b1;
         else if (m_mode == M_REL && m_age >= (i + 1) * STAGGER) d[i] = 1'b1;
      end
      return d;
   endfunction

   always @(posedge refclk) begin
      model_edge();
      #1;
      chk("pll_rst", 32'(pll_rst_o), 32'(m_mode == M_RST || m_mode == M_FLT));
      chk("dom", 32'(domain_rst_n_o), exp_dom());
      chk("locked", 32'(locked_o), 32'(m_mode == M_RUN));
      chk("fault", 32'(fault_o), 32'(m_mode == M_FLT));
      chk("retry", 32'(retry_cnt_o), 32'(m_retry));
      chk("loss", 32'(loss_cnt_o), 32'(m_loss));
   end

   task automatic tick();
      @(posedge refclk);
      #2;
   endtask

   task automatic wait_locked(input string tag);
      int n;
      n = 0;
      while (locked_o !== 1'b1 && n < 150) begin
         tick();
         n++;
      end
      chk(tag, 32'(n < 150), 32'd1);
   endtask

   task automatic pulse_relock();
      @(negedge refclk);
      relock_req_i = 1'b1;
      @(negedge refclk);
      relock_req_i = 1'b0;
   endtask

   int n;
   int seg_len;
   int seg_kind;

   initial begin
      // reset state
      repeat (3) tick();
      chk("rst_pll", 32'(pll_rst_o), 32'd1);
      chk("rst_dom", 32'(domain_rst_n_o), 32'd0);
      chk("rst_cnt", {20'd0, retry_cnt_o, loss_cnt_o}, 32'd0);

      // nominal: PLL reset spans four cycles, lock raised at cycle 10
      @(negedge refclk);
      rst_n = 1'b1;
      repeat (3) tick();
      chk("nom_rst_hi", 32'(pll_rst_o), 32'd1);
      tick();
      chk("nom_rst_lo", 32'(pll_rst_o), 32'd0);
      repeat (5) @(negedge refclk);
      pll_locked_i = 1'b1;
      n = 0;
      while (domain_rst_n_o !== 3'b001 && n < 60) begin
         tick();
         n++;
      end
      chk("nom_dom1", 32'(domain_rst_n_o), 32'd1);
      repeat (2) tick();
      chk("nom_dom2", 32'(domain_rst_n_o), 32'd3);
      repeat (2) tick();
      chk("nom_dom3", 32'(domain_rst_n_o), 32'd7);
      wait_locked("nom_lock");

      // lock loss in RUN
      @(negedge refclk);
      pll_locked_i = 1'b0;
      repeat (2) tick();
      chk("loss_hold", 32'(domain_rst_n_o), 32'd7);
      tick();
      chk("loss_dom", 32'(domain_rst_n_o), 32'd0);
      chk("loss_cnt", 32'(loss_cnt_o), 32'd1);
      chk("loss_pll", 32'(pll_rst_o), 32'd1);
      @(negedge refclk);
      pll_locked_i = 1'b1;
      wait_locked("loss_relock");

      // relock request and synced lock drop hit the FSM together
      @(negedge refclk);
      pll_locked_i = 1'b0;
      repeat (2) @(negedge refclk);
      relock_req_i = 1'b1;
      @(negedge refclk);
      relock_req_i = 1'b0;
      chk("sim_loss", 32'(loss_cnt_o), 32'd2);
      chk("sim_pll", 32'(pll_rst_o), 32'd1);
      pll_locked_i = 1'b1;
      wait_locked("sim_relock");
      chk("sim_loss_after", 32'(loss_cnt_o), 32'd2);

      // glitching lock never satisfies the filter, attempt times out
      pulse_relock();
      n = 0;
      while (retry_cnt_o !== 4'd1 && n < 200) begin
         @(negedge refclk);
         pll_locked_i = (n % 6 != 5);
         tick();
         n++;
      end
      chk("glitch_retry", 32'(retry_cnt_o), 32'd1);
      chk("glitch_pll", 32'(pll_rst_o), 32'd1);
      chk("glitch_loss", 32'(loss_cnt_o), 32'd2);

      // persistent no-lock runs into FAULT, relock request recovers
      @(negedge refclk);
      pll_locked_i = 1'b0;
      n = 0;
      while (fault_o !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      chk("flt_seen", 32'(fault_o), 32'd1);
      chk("flt_retry", 32'(retry_cnt_o), 32'd3);
      chk("flt_pll", 32'(pll_rst_o), 32'd1);
      @(negedge refclk);
      pll_locked_i = 1'b1;
      repeat (5) tick();
      chk("flt_sticky", 32'(fault_o), 32'd1);
      pulse_relock();
      wait_locked("flt_recover");
      chk("flt_clear", 32'(fault_o), 32'd0);
      chk("flt_retry0", 32'(retry_cnt_o), 32'd0);

      // random lock segments, relock pulses and occasional resets
      for (int s = 0; s < 140; s++) begin
         seg_len  = $urandom_range(1, 40);
         seg_kind = $urandom_range(0, 9);
         for (int k = 0; k < seg_len; k++) begin
            @(negedge refclk);
            if (seg_kind < 6) pll_locked_i = 1'b1;
            else if (seg_kind < 8) pll_locked_i = 1'b0;
            else pll_locked_i = 1'($urandom_range(0, 1));
            relock_req_i = ($urandom_range(0, 149) == 0);
            rst_n = ($urandom_range(0, 799) != 0);
         end
      end
      @(negedge refclk);
      rst_n = 1'b1;
      relock_req_i = 1'b0;
      pll_locked_i = 1'b1;

      // synchronous reset in the middle of RELEASE
      pulse_relock();
      n = 0;
      while (domain_rst_n_o !== 3'b011 && n < 200) begin
         tick();
         n++;
      end
      chk("mid_rel_dom", 32'(domain_rst_n_o), 32'd3);
      @(negedge refclk);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_pll", 32'(pll_rst_o), 32'd1);
      chk("mid_rst_dom", 32'(domain_rst_n_o), 32'd0);
      chk("mid_rst_flags", {30'd0, locked_o, fault_o}, 32'd0);
      chk("mid_rst_cnt", {20'd0, retry_cnt_o, loss_cnt_o}, 32'd0);
      @(negedge refclk);
      rst_n = 1'b1;
      repeat (4) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
